// File: rtl/sound_frame_tx.sv
// sound_frame_tx: transmit framer for the sound byte link.
// Buffers 32-bit sample words in a small FIFO. After reset it sends a sync
// preamble, then serializes each word MSB byte first onto an 8-bit stream.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   aclr         synchronous clear: flush FIFO, drop the word in flight
//   in_valid     in_data holds a word
//   in_data      32-bit sample word, [31:24] is sent first
//   in_ready     FIFO can take a word (~full & ~aclr)
//   out_ready    downstream takes the byte this cycle
//   out_valid    out_data holds a byte (registered)
//   out_data     link byte (registered)
//   out_sync     out_data is a preamble byte (registered)
//   busy         in SYNC or SEND, or FIFO non-empty
module sound_frame_tx #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter logic [7:0]  SYNC_BYTE  = 8'hFF,
    parameter int unsigned SYNC_COUNT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        aclr,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sync,
    output logic        busy
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    logic [31:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;

    state_t      r_state;
    logic        r_sync_done;
    logic [3:0]  r_sync_cnt;
    logic [1:0]  r_idx;
    logic [23:0] r_shift;     // bytes still to send after the one on out_data
    logic        r_out_valid;
    logic [7:0]  r_out_data;
    logic        r_out_sync;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_xfer;
    logic        w_sync_last;
    logic [31:0] w_head;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign in_ready    = ~w_full & ~aclr;
    assign w_push      = in_valid & in_ready;
    assign w_xfer      = r_out_valid & out_ready;
    assign w_sync_last = (r_sync_cnt == 4'(SYNC_COUNT - 1));
    assign w_head      = r_mem[r_rd_ptr];

    // Pop whenever the shifter is free to take a new word this edge.
    assign w_pop = ~aclr & ~w_empty &
                   ((r_state == ST_IDLE) |
                    ((r_state == ST_SYNC) & w_xfer & w_sync_last) |
                    ((r_state == ST_SEND) & w_xfer & (r_idx == 2'd0)));

    assign busy      = (r_state != ST_IDLE) | ~w_empty;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sync  = r_out_sync;

    // Word storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (aclr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Framer FSM with registered byte outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_SYNC;
            r_sync_done <= 1'b0;
            r_sync_cnt  <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_sync  <= 1'b0;
        end else if (aclr) begin
            r_state     <= r_sync_done ? ST_IDLE : ST_SYNC;
            r_sync_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_sync  <= 1'b0;
        end else begin
            case (r_state)
                ST_SYNC: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= SYNC_BYTE;
                        r_out_sync  <= 1'b1;
                    end else if (w_xfer) begin
                        if (w_sync_last) begin
                            r_sync_done <= 1'b1;
                            r_sync_cnt  <= '0;
                            r_out_sync  <= 1'b0;
                            if (w_pop) begin
                                r_out_data <= w_head[31:24];
                                r_shift    <= w_head[23:0];
                                r_idx      <= 2'd3;
                                r_state    <= ST_SEND;
                            end else begin
                                r_out_valid <= 1'b0;
                                r_state     <= ST_IDLE;
                            end
                        end else begin
                            r_sync_cnt <= r_sync_cnt + 4'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (w_pop) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_head[31:24];
                        r_out_sync  <= 1'b0;
                        r_shift     <= w_head[23:0];
                        r_idx       <= 2'd3;
                        r_state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        if (r_idx != 2'd0) begin
                            r_idx      <= r_idx - 2'd1;
                            r_out_data <= r_shift[23:16];
                            r_shift    <= {r_shift[15:0], 8'h00};
                        end else if (w_pop) begin
                            // Back-to-back word: no bubble between words.
                            r_out_data <= w_head[31:24];
                            r_shift    <= w_head[23:0];
                            r_idx      <= 2'd3;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_out_sync  <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sound_frame_tx.sv
// Testbench for sound_frame_tx: table-driven per-cycle vectors with
// hand-computed outputs, a far-end receiver model that rebuilds words,
// and hand sequences for asynchronous reset and aclr during the preamble.
module tb_sound_frame_tx;

    logic        clk;
    logic        reset;
    logic        aclr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sync;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;

    sound_frame_tx dut (
        .clk       (clk),
        .reset     (reset),
        .aclr      (aclr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sync  (out_sync),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Far-end receiver: arms on a sync transfer, then shifts in data bytes.
    logic        rx_armed;
    logic [1:0]  rx_n;
    logic [23:0] rx_sh;
    logic [31:0] rx_words [$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_armed <= 1'b0;
            rx_n     <= 2'd0;
            rx_sh    <= '0;
        end else if (aclr) begin
            rx_n <= 2'd0;
        end else if (out_valid && out_ready) begin
            if (out_sync) begin
                rx_armed <= 1'b1;
            end else if (rx_armed) begin
                rx_sh <= {rx_sh[15:0], out_data};
                if (rx_n == 2'd3) rx_words.push_back({rx_sh, out_data});
                rx_n <= rx_n + 2'd1;
            end
        end
    end

    typedef struct {
        logic        aclr;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_irdy;
        logic        e_v;
        logic [7:0]  e_d;
        logic        e_s;
        logic        e_busy;
    } vec_t;

    vec_t tbl_a [$];
    vec_t tbl_b [$];

    function automatic vec_t mk(input logic a, input logic iv, input logic [31:0] id,
                                input logic ordy, input logic irdy, input logic v,
                                input logic [7:0] d, input logic s, input logic b);
        vec_t r;
        r.aclr = a; r.iv = iv; r.id = id; r.ordy = ordy;
        r.e_irdy = irdy; r.e_v = v; r.e_d = d; r.e_s = s; r.e_busy = b;
        return r;
    endfunction

    task automatic chk(input string nm, input string f, input logic [31:0] got,
                       input logic [31:0] exp);
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s %s: got %0h expected %0h", nm, f, got, exp);
        end
    endtask

    // Drive inputs just after an edge, check in_ready, then the next edge's outputs.
    task automatic apply(input vec_t v, input string nm);
        aclr      = v.aclr;
        in_valid  = v.iv;
        in_data   = v.id;
        out_ready = v.ordy;
        #2;
        chk(nm, "in_ready", 32'(in_ready), 32'(v.e_irdy));
        @(posedge clk);
        #1;
        chk(nm, "out_valid", 32'(out_valid), 32'(v.e_v));
        if (v.e_v) chk(nm, "out_data", 32'(out_data), 32'(v.e_d));
        chk(nm, "out_sync", 32'(out_sync), 32'(v.e_s));
        chk(nm, "busy", 32'(busy), 32'(v.e_busy));
        n_vec++;
    endtask

    task automatic chk_rx(input string nm, input logic [31:0] exp [$]);
        chk(nm, "rx_count", 32'(rx_words.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < rx_words.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), "rx_word", rx_words[i], exp[i]);
        n_vec++;
    endtask

    logic [31:0] exp_words [$];

    initial begin
        // Preamble, single word, sync-valued data
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'hFF,1,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,0,8'h00,0,0));
        tbl_a.push_back(mk(0,1,32'h12345678,1, 1,0,8'h00,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h12,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h34,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h56,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h78,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,0,8'h00,0,0));
        tbl_a.push_back(mk(0,1,32'hFFFF00FF,1, 1,0,8'h00,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'hFF,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'hFF,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h00,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'hFF,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,0,8'h00,0,0));
        // Fill with out_ready low: one word in the shifter, four in the FIFO
        tbl_a.push_back(mk(0,1,32'h10111213,0, 1,0,8'h00,0,1));
        tbl_a.push_back(mk(0,1,32'h20212223,0, 1,1,8'h10,0,1));
        tbl_a.push_back(mk(0,1,32'h30313233,0, 1,1,8'h10,0,1));
        tbl_a.push_back(mk(0,1,32'h40414243,0, 1,1,8'h10,0,1));
        tbl_a.push_back(mk(0,1,32'h50515253,0, 1,1,8'h10,0,1));
        tbl_a.push_back(mk(0,1,32'h60616263,0, 0,1,8'h10,0,1));
        // Drain with no bubbles; W6 held until a slot opens
        tbl_a.push_back(mk(0,1,32'h60616263,1, 0,1,8'h11,0,1));
        tbl_a.push_back(mk(0,1,32'h60616263,1, 0,1,8'h12,0,1));
        tbl_a.push_back(mk(0,1,32'h60616263,1, 0,1,8'h13,0,1));
        tbl_a.push_back(mk(0,1,32'h60616263,1, 0,1,8'h20,0,1));
        tbl_a.push_back(mk(0,1,32'h60616263,1, 1,1,8'h21,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        0,1,8'h22,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        0,1,8'h23,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        0,1,8'h30,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h31,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h32,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h33,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h40,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h41,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h42,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h43,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h50,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h51,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h52,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h53,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h60,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h61,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h62,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h63,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,0,8'h00,0,0));
        // Stall pattern 1,0,0,1 during SEND
        tbl_a.push_back(mk(0,1,32'h12345678,1, 1,0,8'h00,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h12,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h34,0,1));
        tbl_a.push_back(mk(0,0,32'h0,0,        1,1,8'h34,0,1));
        tbl_a.push_back(mk(0,0,32'h0,0,        1,1,8'h34,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h56,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'h78,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,0,8'h00,0,0));
        // aclr mid-word with two words queued; in_valid ignored in aclr cycle
        tbl_a.push_back(mk(0,1,32'h12345678,1, 1,0,8'h00,0,1));
        tbl_a.push_back(mk(0,1,32'h01020304,1, 1,1,8'h12,0,1));
        tbl_a.push_back(mk(0,1,32'h05060708,1, 1,1,8'h34,0,1));
        tbl_a.push_back(mk(1,1,32'hDEADBEEF,1, 0,0,8'h00,0,0));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,0,8'h00,0,0));
        tbl_a.push_back(mk(0,1,32'hAABBCCDD,1, 1,0,8'h00,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'hAA,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'hBB,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'hCC,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,1,8'hDD,0,1));
        tbl_a.push_back(mk(0,0,32'h0,1,        1,0,8'h00,0,0));

        // After a mid-operation reset: aclr during SYNC restarts the preamble,
        // a word written during SYNC loads straight after it, aclr in IDLE
        // does not bring the preamble back.
        tbl_b.push_back(mk(0,0,32'h0,0,        1,1,8'hFF,1,1));
        tbl_b.push_back(mk(0,0,32'h0,0,        1,1,8'hFF,1,1));
        tbl_b.push_back(mk(1,1,32'h55555555,0, 0,0,8'h00,0,1));
        tbl_b.push_back(mk(0,1,32'h0A0B0C0D,0, 1,1,8'hFF,1,1));
        tbl_b.push_back(mk(0,0,32'h0,1,        1,1,8'h0A,0,1));
        tbl_b.push_back(mk(0,0,32'h0,1,        1,1,8'h0B,0,1));
        tbl_b.push_back(mk(0,0,32'h0,1,        1,1,8'h0C,0,1));
        tbl_b.push_back(mk(0,0,32'h0,1,        1,1,8'h0D,0,1));
        tbl_b.push_back(mk(0,0,32'h0,1,        1,0,8'h00,0,0));
        tbl_b.push_back(mk(1,0,32'h0,1,        0,0,8'h00,0,0));
        tbl_b.push_back(mk(0,0,32'h0,1,        1,0,8'h00,0,0));

        // Reset values while reset is held
        reset = 1'b1; aclr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", "out_valid", 32'(out_valid), 32'd0);
        chk("reset", "out_data",  32'(out_data),  32'h00);
        chk("reset", "out_sync",  32'(out_sync),  32'd0);
        chk("reset", "busy",      32'(busy),      32'd1);
        chk("reset", "in_ready",  32'(in_ready),  32'd1);
        n_vec++;
        reset = 1'b0;

        foreach (tbl_a[i]) apply(tbl_a[i], $sformatf("A%0d", i));

        exp_words = '{32'h12345678, 32'hFFFF00FF, 32'h10111213, 32'h20212223,
                      32'h30313233, 32'h40414243, 32'h50515253, 32'h60616263,
                      32'h12345678, 32'hAABBCCDD};
        chk_rx("rx_a", exp_words);

        // Word in flight, then asynchronous reset between edges
        apply(mk(0,1,32'h99887766,0, 1,0,8'h00,0,1), "R0");
        apply(mk(0,0,32'h0,0,        1,1,8'h99,0,1), "R1");
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", "out_valid", 32'(out_valid), 32'd0);
        chk("async_reset", "out_data",  32'(out_data),  32'h00);
        chk("async_reset", "out_sync",  32'(out_sync),  32'd0);
        chk("async_reset", "busy",      32'(busy),      32'd1);
        chk("async_reset", "in_ready",  32'(in_ready),  32'd1);
        n_vec++;
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (tbl_b[i]) apply(tbl_b[i], $sformatf("B%0d", i));

        exp_words.push_back(32'h0A0B0C0D);
        chk_rx("rx_b", exp_words);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
